// File: rtl/multicycle_control_pkg.sv
// rtl/multicycle_control_pkg.sv - shared encodings for the multicycle RISC-V control FSM
package multicycle_control_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_FETCH     = 4'd1,
    ST_DECODE    = 4'd2,
    ST_EXEC_R    = 4'd3,
    ST_EXEC_I    = 4'd4,
    ST_LUI       = 4'd5,
    ST_ALU_WB    = 4'd6,
    ST_MEM_ADDR  = 4'd7,
    ST_MEM_READ  = 4'd8,
    ST_MEM_WB    = 4'd9,
    ST_MEM_WRITE = 4'd10,
    ST_BRANCH    = 4'd11,
    ST_JAL       = 4'd12,
    ST_TRAP      = 4'd13
  } state_e;

  // Which ALU-decode flavour applies to the instruction in IR
  typedef enum logic [1:0] {
    CLS_NONE = 2'd0,
    CLS_R    = 2'd1,
    CLS_I    = 2'd2
  } op_class_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  localparam logic [3:0] ALU_ADD    = 4'd0;
  localparam logic [3:0] ALU_SUB    = 4'd1;
  localparam logic [3:0] ALU_AND    = 4'd2;
  localparam logic [3:0] ALU_OR     = 4'd3;
  localparam logic [3:0] ALU_XOR    = 4'd4;
  localparam logic [3:0] ALU_SLT    = 4'd5;
  localparam logic [3:0] ALU_SLL    = 4'd6;
  localparam logic [3:0] ALU_SRL    = 4'd7;
  localparam logic [3:0] ALU_SRA    = 4'd8;
  localparam logic [3:0] ALU_PASS_B = 4'd9;

  localparam logic [1:0] SRCA_PC     = 2'd0;
  localparam logic [1:0] SRCA_OLD_PC = 2'd1;
  localparam logic [1:0] SRCA_RS1    = 2'd2;
  localparam logic [1:0] SRCB_RS2    = 2'd0;
  localparam logic [1:0] SRCB_IMM    = 2'd1;
  localparam logic [1:0] SRCB_FOUR   = 2'd2;
  localparam logic [1:0] RES_ALU_OUT = 2'd0;
  localparam logic [1:0] RES_MEM     = 2'd1;
  localparam logic [1:0] RES_ALU     = 2'd2;

  localparam logic [1:0] TRAP_NONE    = 2'd0;
  localparam logic [1:0] TRAP_ILLEGAL = 2'd1;
  localparam logic [1:0] TRAP_TIMEOUT = 2'd2;

  function automatic op_class_e op_class(input logic [6:0] opcode);
    case (opcode)
      OPC_OP:     return CLS_R;
      OPC_OP_IMM: return CLS_I;
      default:    return CLS_NONE;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control_alu_decoder.sv
// rtl/multicycle_control_alu_decoder.sv - funct3/funct7_5 to alu_ctrl with illegal-encoding flag
module multicycle_control_alu_decoder
  import multicycle_control_pkg::*;
(
  input  op_class_e  op_class_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7_5_i,
  output logic [3:0] alu_ctrl_o,
  output logic       illegal_o
);

  // Map the arithmetic encodings; SUB only exists for register-register ops
  always_comb begin
    alu_ctrl_o = ALU_ADD;
    illegal_o  = 1'b0;
    if (op_class_i != CLS_NONE) begin
      case (funct3_i)
        3'b000:  alu_ctrl_o = (op_class_i == CLS_R && funct7_5_i) ? ALU_SUB : ALU_ADD;
        3'b111:  alu_ctrl_o = ALU_AND;
        3'b110:  alu_ctrl_o = ALU_OR;
        3'b100:  alu_ctrl_o = ALU_XOR;
        3'b010:  alu_ctrl_o = ALU_SLT;
        3'b001:  alu_ctrl_o = ALU_SLL;
        3'b101:  alu_ctrl_o = funct7_5_i ? ALU_SRA : ALU_SRL;
        default: illegal_o  = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle RISC-V control FSM with memory watchdog (perf counters: CTRL_PERF_COUNTERS_EN)
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255
`ifdef CTRL_PERF_COUNTERS_EN
  , parameter int unsigned CNT_W = 32
`endif
) (
  input  logic       clock_i,
  input  logic       reset_ni,
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7_5_i,
  input  logic       zero_i,
  input  logic       mem_ready_i,
  output logic       mem_req_o,
  output logic       mem_we_o,
  output logic       adr_src_o,
  output logic       ir_write_o,
  output logic       pc_write_o,
  output logic       reg_write_o,
  output logic [1:0] alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [1:0] result_src_o,
  output logic [3:0] alu_ctrl_o,
  output logic       halted_o,
  output logic [1:0] trap_cause_o
`ifdef CTRL_PERF_COUNTERS_EN
  , output logic [CNT_W-1:0] cycle_count_o
  , output logic [CNT_W-1:0] instr_retired_o
`endif
);

  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = (MEM_TIMEOUT > 0) ? WAIT_W'(MEM_TIMEOUT - 1) : '0;

  state_e            state_q, state_d;
  logic [1:0]        cause_q, cause_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [3:0]        dec_alu;
  logic              dec_illegal;
  logic              timeout;

  multicycle_control_alu_decoder u_alu_dec (
    .op_class_i (op_class(opcode_i)),
    .funct3_i   (funct3_i),
    .funct7_5_i (funct7_5_i),
    .alu_ctrl_o (dec_alu),
    .illegal_o  (dec_illegal)
  );

  // Datapath controls are a function of the current state, gated by ready/zero where needed
  always_comb begin
    mem_req_o    = 1'b0;
    mem_we_o     = 1'b0;
    adr_src_o    = 1'b0;
    ir_write_o   = 1'b0;
    pc_write_o   = 1'b0;
    reg_write_o  = 1'b0;
    alu_src_a_o  = SRCA_PC;
    alu_src_b_o  = SRCB_RS2;
    result_src_o = RES_ALU_OUT;
    alu_ctrl_o   = ALU_ADD;
    halted_o     = 1'b0;
    case (state_q)
      ST_FETCH: begin
        mem_req_o = 1'b1;
        if (mem_ready_i) begin
          ir_write_o   = 1'b1;
          pc_write_o   = 1'b1;
          alu_src_b_o  = SRCB_FOUR;
          result_src_o = RES_ALU;
        end
      end
      ST_DECODE:   begin alu_src_a_o = SRCA_OLD_PC; alu_src_b_o = SRCB_IMM; end
      ST_EXEC_R:   begin alu_src_a_o = SRCA_RS1; alu_ctrl_o = dec_alu; end
      ST_EXEC_I:   begin alu_src_a_o = SRCA_RS1; alu_src_b_o = SRCB_IMM; alu_ctrl_o = dec_alu; end
      ST_LUI:      begin alu_src_b_o = SRCB_IMM; alu_ctrl_o = ALU_PASS_B; end
      ST_ALU_WB:   reg_write_o = 1'b1;
      ST_MEM_ADDR: begin alu_src_a_o = SRCA_RS1; alu_src_b_o = SRCB_IMM; end
      ST_MEM_READ: begin mem_req_o = 1'b1; adr_src_o = 1'b1; end
      ST_MEM_WB:   begin result_src_o = RES_MEM; reg_write_o = 1'b1; end
      ST_MEM_WRITE: begin mem_req_o = 1'b1; mem_we_o = 1'b1; adr_src_o = 1'b1; end
      ST_BRANCH: begin
        alu_src_a_o = SRCA_RS1;
        alu_ctrl_o  = ALU_SUB;
        pc_write_o  = (funct3_i == 3'b000 && zero_i) || (funct3_i == 3'b001 && !zero_i);
      end
      ST_JAL:      begin alu_src_a_o = SRCA_OLD_PC; alu_src_b_o = SRCB_FOUR; pc_write_o = 1'b1; end
      ST_TRAP:     halted_o = 1'b1;
      default: ;
    endcase
  end

  assign trap_cause_o = cause_q;

  // Sequencing; a completing memory access takes priority over the watchdog
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    timeout = (MEM_TIMEOUT != 0) && mem_req_o && !mem_ready_i && (wait_q == WAIT_LIMIT);
    case (state_q)
      ST_IDLE:  state_d = ST_FETCH;
      ST_FETCH: begin
        if (mem_ready_i)  state_d = ST_DECODE;
        else if (timeout) begin state_d = ST_TRAP; cause_d = TRAP_TIMEOUT; end
      end
      ST_DECODE: begin
        case (opcode_i)
          OPC_OP:     state_d = ST_EXEC_R;
          OPC_OP_IMM: state_d = ST_EXEC_I;
          OPC_LOAD, OPC_STORE: state_d = ST_MEM_ADDR;
          OPC_BRANCH: state_d = ST_BRANCH;
          OPC_JAL:    state_d = ST_JAL;
          OPC_LUI:    state_d = ST_LUI;
          default:    state_d = ST_TRAP;
        endcase
        if (state_d == ST_TRAP || dec_illegal) begin
          state_d = ST_TRAP;
          cause_d = TRAP_ILLEGAL;
        end
      end
      ST_EXEC_R, ST_EXEC_I, ST_LUI, ST_JAL: state_d = ST_ALU_WB;
      ST_ALU_WB, ST_MEM_WB: state_d = ST_FETCH;
      ST_MEM_ADDR: state_d = (opcode_i == OPC_LOAD) ? ST_MEM_READ : ST_MEM_WRITE;
      ST_MEM_READ, ST_MEM_WRITE: begin
        if (mem_ready_i)  state_d = (state_q == ST_MEM_READ) ? ST_MEM_WB : ST_FETCH;
        else if (timeout) begin state_d = ST_TRAP; cause_d = TRAP_TIMEOUT; end
      end
      ST_BRANCH: begin
        if (funct3_i == 3'b000 || funct3_i == 3'b001) state_d = ST_FETCH;
        else begin state_d = ST_TRAP; cause_d = TRAP_ILLEGAL; end
      end
      ST_TRAP: state_d = ST_TRAP;
      default: state_d = ST_IDLE;
    endcase
    if (state_d != state_q || mem_ready_i) wait_d = '0;
    else if (mem_req_o)                     wait_d = wait_q + WAIT_W'(1);
    else                                    wait_d = wait_q;
  end

  // State, trap cause and watchdog registers
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= ST_IDLE;
      cause_q <= TRAP_NONE;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      wait_q  <= wait_d;
    end
  end

`ifdef CTRL_PERF_COUNTERS_EN
  logic retire;
  assign retire = (state_d == ST_FETCH) &&
                  (state_q inside {ST_ALU_WB, ST_MEM_WB, ST_MEM_WRITE, ST_BRANCH});

  // Active-cycle and retired-instruction counters, frozen while idle or trapped
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      cycle_count_o   <= '0;
      instr_retired_o <= '0;
    end else begin
      if (state_q != ST_IDLE && state_q != ST_TRAP) cycle_count_o <= cycle_count_o + CNT_W'(1);
      if (retire) instr_retired_o <= instr_retired_o + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - table-driven cycle-accurate check of multicycle_control
module tb_multicycle_control;

  localparam logic [6:0] OP_R  = 7'h33;
  localparam logic [6:0] OP_I  = 7'h13;
  localparam logic [6:0] OP_LD = 7'h03;
  localparam logic [6:0] OP_ST = 7'h23;
  localparam logic [6:0] OP_BR = 7'h63;
  localparam logic [6:0] OP_JL = 7'h6F;
  localparam logic [6:0] OP_LU = 7'h37;

  typedef struct packed {
    logic       req, we, adr, irw, pcw, rw;
    logic [1:0] a, b, rs;
    logic [3:0] alu;
    logic       h;
    logic [1:0] c;
  } out_t;

  typedef struct {
    logic       rst_n;
    logic [6:0] opc;
    logic [2:0] f3;
    logic       f7;
    logic       z;
    logic       rdy;
    out_t       exp;
  } vec_t;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [6:0] opcode = '0;
  logic [2:0] funct3 = '0;
  logic       funct7_5 = 1'b0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, mem_we, adr_src, ir_write, pc_write, reg_write, halted;
  logic [1:0] alu_src_a, alu_src_b, result_src, trap_cause;
  logic [3:0] alu_ctrl;
`ifdef CTRL_PERF_COUNTERS_EN
  logic [31:0] cycle_count, instr_retired;
`endif

  multicycle_control #(.MEM_TIMEOUT(4)) dut (
    .clock_i      (clock),
    .reset_ni     (reset_n),
    .opcode_i     (opcode),
    .funct3_i     (funct3),
    .funct7_5_i   (funct7_5),
    .zero_i       (zero),
    .mem_ready_i  (mem_ready),
    .mem_req_o    (mem_req),
    .mem_we_o     (mem_we),
    .adr_src_o    (adr_src),
    .ir_write_o   (ir_write),
    .pc_write_o   (pc_write),
    .reg_write_o  (reg_write),
    .alu_src_a_o  (alu_src_a),
    .alu_src_b_o  (alu_src_b),
    .result_src_o (result_src),
    .alu_ctrl_o   (alu_ctrl),
    .halted_o     (halted),
    .trap_cause_o (trap_cause)
`ifdef CTRL_PERF_COUNTERS_EN
    , .cycle_count_o   (cycle_count)
    , .instr_retired_o (instr_retired)
`endif
  );

  always #5 clock = ~clock;

  vec_t       vecs[$];
  out_t       sb[$];
  logic [6:0] cur_opc;
  logic [2:0] cur_f3;
  logic       cur_f7;
  int         n_vec = 0;
  int         n_bad = 0;

  function automatic out_t mk(input int req, we, adr, irw, pcw, rw, a, b, rs, alu, h, c);
    out_t r;
    r.req = req[0]; r.we = we[0]; r.adr = adr[0]; r.irw = irw[0]; r.pcw = pcw[0]; r.rw = rw[0];
    r.a = a[1:0]; r.b = b[1:0]; r.rs = rs[1:0]; r.alu = alu[3:0]; r.h = h[0]; r.c = c[1:0];
    return r;
  endfunction

  function automatic out_t o_idle();          return mk(0,0,0,0,0,0, 0,0,0,0, 0,0); endfunction
  function automatic out_t o_fw();            return mk(1,0,0,0,0,0, 0,0,0,0, 0,0); endfunction
  function automatic out_t o_fr();            return mk(1,0,0,1,1,0, 0,2,2,0, 0,0); endfunction
  function automatic out_t o_dec();           return mk(0,0,0,0,0,0, 1,1,0,0, 0,0); endfunction
  function automatic out_t o_exr(input int a); return mk(0,0,0,0,0,0, 2,0,0,a, 0,0); endfunction
  function automatic out_t o_exi(input int a); return mk(0,0,0,0,0,0, 2,1,0,a, 0,0); endfunction
  function automatic out_t o_lui();           return mk(0,0,0,0,0,0, 0,1,0,9, 0,0); endfunction
  function automatic out_t o_awb();           return mk(0,0,0,0,0,1, 0,0,0,0, 0,0); endfunction
  function automatic out_t o_ma();            return mk(0,0,0,0,0,0, 2,1,0,0, 0,0); endfunction
  function automatic out_t o_mr();            return mk(1,0,1,0,0,0, 0,0,0,0, 0,0); endfunction
  function automatic out_t o_mwb();           return mk(0,0,0,0,0,1, 0,0,1,0, 0,0); endfunction
  function automatic out_t o_mw();            return mk(1,1,1,0,0,0, 0,0,0,0, 0,0); endfunction
  function automatic out_t o_br(input int p);  return mk(0,0,0,0,p,0, 2,0,0,1, 0,0); endfunction
  function automatic out_t o_jal();           return mk(0,0,0,0,1,0, 1,2,0,0, 0,0); endfunction
  function automatic out_t o_trap(input int c); return mk(0,0,0,0,0,0, 0,0,0,0, 1,c); endfunction

  task automatic set_ir(input logic [6:0] opc, input logic [2:0] f3, input logic f7);
    cur_opc = opc; cur_f3 = f3; cur_f7 = f7;
  endtask

  task automatic add(input logic rst, input logic z, input logic rdy, input out_t e);
    vec_t v;
    v.rst_n = rst; v.opc = cur_opc; v.f3 = cur_f3; v.f7 = cur_f7;
    v.z = z; v.rdy = rdy; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic fetch(input int waits);
    for (int k = 0; k < waits; k++) add(1, 0, 0, o_fw());
    add(1, 0, 1, o_fr());
  endtask

  task automatic alu_instr(input logic [6:0] opc, input logic [2:0] f3, input logic f7, input int alu);
    set_ir(opc, f3, f7);
    fetch(0);
    add(1, 0, 0, o_dec());
    if (opc == OP_R) add(1, 0, 0, o_exr(alu));
    else             add(1, 0, 0, o_exi(alu));
    add(1, 0, 0, o_awb());
  endtask

  task automatic branch(input logic [2:0] f3, input logic z, input int pcw);
    set_ir(OP_BR, f3, 1'b0);
    fetch(0);
    add(1, z, 0, o_dec());
    add(1, z, 0, o_br(pcw));
  endtask

  task automatic do_reset();
    add(0, 0, 0, o_idle());
    add(1, 0, 0, o_idle());
  endtask

  initial begin
    out_t act, e;
    logic prev_h;
`ifdef CTRL_PERF_COUNTERS_EN
    logic [31:0] snap_cc, snap_ir;
`endif
    prev_h = 1'b0;
    set_ir(OP_R, 3'b000, 1'b0);
    // reset held three cycles, then IDLE, then FETCH
    add(0, 0, 0, o_idle()); add(0, 0, 0, o_idle()); add(0, 0, 0, o_idle());
    add(1, 0, 0, o_idle());
    alu_instr(OP_R, 3'b000, 1'b0, 0);
    alu_instr(OP_R, 3'b000, 1'b1, 1);
    alu_instr(OP_I, 3'b000, 1'b1, 0);
    alu_instr(OP_R, 3'b111, 1'b0, 2);
    alu_instr(OP_I, 3'b110, 1'b0, 3);
    alu_instr(OP_R, 3'b100, 1'b0, 4);
    alu_instr(OP_I, 3'b010, 1'b0, 5);
    alu_instr(OP_R, 3'b001, 1'b0, 6);
    alu_instr(OP_R, 3'b101, 1'b0, 7);
    alu_instr(OP_I, 3'b101, 1'b1, 8);
    set_ir(OP_LU, 3'b000, 1'b0);
    fetch(0); add(1, 0, 0, o_dec()); add(1, 0, 0, o_lui()); add(1, 0, 0, o_awb());
    // load with three stall cycles; ready on the last allowed cycle beats the watchdog
    set_ir(OP_LD, 3'b010, 1'b0);
    fetch(0); add(1, 0, 0, o_dec()); add(1, 0, 0, o_ma());
    add(1, 0, 0, o_mr()); add(1, 0, 0, o_mr()); add(1, 0, 0, o_mr()); add(1, 0, 1, o_mr());
    add(1, 0, 0, o_mwb());
    set_ir(OP_ST, 3'b010, 1'b0);
    fetch(2); add(1, 0, 0, o_dec()); add(1, 0, 0, o_ma());
    add(1, 0, 0, o_mw()); add(1, 0, 1, o_mw());
    branch(3'b000, 1'b1, 1);
    branch(3'b000, 1'b0, 0);
    branch(3'b001, 1'b0, 1);
    branch(3'b001, 1'b1, 0);
    set_ir(OP_JL, 3'b000, 1'b0);
    fetch(0); add(1, 0, 0, o_dec()); add(1, 0, 0, o_jal()); add(1, 0, 0, o_awb());
    // fetch answered on the 4th cycle: no timeout
    set_ir(OP_R, 3'b000, 1'b0);
    fetch(3); add(1, 0, 0, o_dec()); add(1, 0, 0, o_exr(0)); add(1, 0, 0, o_awb());
    // illegal branch funct3 traps without writing PC
    branch(3'b010, 1'b1, 0);
    add(1, 0, 0, o_trap(1)); add(1, 0, 0, o_trap(1));
    // fetch never answered: trap with cause 2 after four cycles
    do_reset();
    set_ir(OP_R, 3'b000, 1'b0);
    add(1, 0, 0, o_fw()); add(1, 0, 0, o_fw()); add(1, 0, 0, o_fw()); add(1, 0, 0, o_fw());
    add(1, 0, 1, o_trap(2)); add(1, 0, 0, o_trap(2));
    // unsupported opcode (SYSTEM)
    do_reset();
    set_ir(7'h73, 3'b000, 1'b0);
    fetch(0); add(1, 0, 0, o_dec());
    add(1, 0, 0, o_trap(1)); add(1, 0, 0, o_trap(1)); add(1, 0, 0, o_trap(1));
    // R-type funct3=011 is illegal in this subset
    do_reset();
    set_ir(OP_R, 3'b011, 1'b0);
    fetch(0); add(1, 0, 0, o_dec()); add(1, 0, 0, o_trap(1));
    // reset mid-fetch drops mem_req immediately, then normal restart
    do_reset();
    set_ir(OP_R, 3'b000, 1'b0);
    add(1, 0, 0, o_fw());
    do_reset();
    fetch(1); add(1, 0, 0, o_dec()); add(1, 0, 0, o_exr(0)); add(1, 0, 0, o_awb());
    fetch(0);

    @(negedge clock);
    for (int i = 0; i < vecs.size(); i++) begin
      reset_n   = vecs[i].rst_n;
      opcode    = vecs[i].opc;
      funct3    = vecs[i].f3;
      funct7_5  = vecs[i].f7;
      zero      = vecs[i].z;
      mem_ready = vecs[i].rdy;
      sb.push_back(vecs[i].exp);
      #2;
      e   = sb.pop_front();
      act = {mem_req, mem_we, adr_src, ir_write, pc_write, reg_write,
             alu_src_a, alu_src_b, result_src, alu_ctrl, halted, trap_cause};
      n_vec++;
      if (act !== e) begin
        n_bad++;
        $display("FAIL row%0d outputs: got %h want %h (req/we/adr/irw/pcw/rw,a,b,rs,alu,h,c)", i, act, e);
      end
`ifdef CTRL_PERF_COUNTERS_EN
      if (e.h && prev_h) begin
        n_vec++;
        if (cycle_count !== snap_cc || instr_retired !== snap_ir) begin
          n_bad++;
          $display("FAIL row%0d counters_frozen: got %0d/%0d want %0d/%0d", i, cycle_count, instr_retired, snap_cc, snap_ir);
        end
      end
      if (!vecs[i].rst_n) begin
        n_vec++;
        if (cycle_count !== 32'd0 || instr_retired !== 32'd0) begin
          n_bad++;
          $display("FAIL row%0d counters_reset: got %0d/%0d want 0/0", i, cycle_count, instr_retired);
        end
      end
      snap_cc = cycle_count;
      snap_ir = instr_retired;
`endif
      prev_h = e.h;
      @(negedge clock);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
